// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: drives a request/acknowledge instruction memory,
// presents fetched words to IF/ID, and steers the PC with delay-slot redirects.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        stall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc4,
    output logic [31:0] if_inst,
    output logic        if_valid
);

    localparam logic [1:0] ST_RST  = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pend_pc_r;
    logic        pend_valid_r;
    logic [31:0] hold_r;

    logic [31:0] pc4_s;
    logic [31:0] target_s;
    logic [31:0] next_pc_s;
    logic        redirect_s;
    logic        bypass_s;
    logic        capture_s;
    logic        present_s;
    logic        handover_s;

    // Next-PC selection, handover decode and state transitions.
    always_comb begin
        pc4_s      = pc_r + 32'd4;
        redirect_s = (stall == 1'b0) && (pcsource != 2'b00);
        case (pcsource)
            2'b01:   target_s = bpc;
            2'b10:   target_s = rpc;
            2'b11:   target_s = jpc;
            default: target_s = pc4_s;
        endcase

        bypass_s   = (state_r == ST_REQ) && imem_ack;
        capture_s  = bypass_s && stall;
        present_s  = bypass_s || (state_r == ST_HOLD);
        handover_s = present_s && !stall;

        // A same-cycle redirect beats an older pending one.
        if (redirect_s) begin
            next_pc_s = target_s;
        end else if (pend_valid_r) begin
            next_pc_s = pend_pc_r;
        end else begin
            next_pc_s = pc4_s;
        end

        case (state_r)
            ST_RST:  state_nxt_s = ST_REQ;
            ST_REQ:  state_nxt_s = capture_s ? ST_HOLD : ST_REQ;
            ST_HOLD: state_nxt_s = stall ? ST_HOLD : ST_REQ;
            default: state_nxt_s = ST_RST;
        endcase
    end

    // Output decode; the REQ path bypasses memory data straight to IF/ID.
    always_comb begin
        imem_req  = (state_r == ST_REQ);
        imem_addr = pc_r;
        if_pc4    = pc4_s;
        if_valid  = present_s;
        if (bypass_s) begin
            if_inst = imem_rdata;
        end else if (state_r == ST_HOLD) begin
            if_inst = hold_r;
        end else begin
            if_inst = 32'h0000_0000;
        end
    end

    // State, PC, pending redirect and hold buffer.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r      <= ST_RST;
            pc_r         <= RESET_PC;
            pend_pc_r    <= 32'h0000_0000;
            pend_valid_r <= 1'b0;
            hold_r       <= 32'h0000_0000;
        end else begin
            state_r <= state_nxt_s;
            if (handover_s) begin
                pc_r         <= next_pc_s;
                pend_valid_r <= 1'b0;
            end else if (redirect_s) begin
                pend_pc_r    <= target_s;
                pend_valid_r <= 1'b1;
            end
            if (capture_s) begin
                hold_r <= imem_rdata;
            end
        end
    end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 clr  in  1  asynchronous, active-high reset.
REQ-004 stall  in  1  hazard-unit stall; 1 = ID holds, no handover this cycle.
REQ-005 pcsource  in  2  next-PC select from ID: 00 pc+4, 01 bpc, 10 rpc, 11 jpc.
REQ-006 bpc / rpc / jpc  in  32 each  branch, jump-register and jump targets from ID.
REQ-007 imem_req  out  1  instruction-memory request, level.
REQ-008 imem_addr  out  32  fetch address, equal to PC.
REQ-009 imem_ack  in  1  memory returns word this cycle; may assert in the same cycle as imem_req.
REQ-010 imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-011 if_pc4  out  32  PC+4 of presented word, feeds IF/ID pipeline register.
REQ-012 if_inst  out  32  presented instruction, feeds IF/ID pipeline register.
REQ-013 if_valid  out  1  1 = if_inst is a real fetched word.

Function
REQ-014 State machine SHALL have states RST, REQ, HOLD; RST SHALL go to REQ unconditionally next cycle.
REQ-015 imem_req SHALL be 1 only in REQ; imem_addr SHALL equal PC in all states.
REQ-016 imem_ack SHALL be ignored in RST and HOLD.
REQ-017 REQ, imem_ack=0: stay REQ, PC held, if_valid=0.
REQ-018 REQ, imem_ack=1, stall=0: combinational bypass; if_valid=1, if_inst=imem_rdata; handover at this edge, PC <= next PC, stay REQ.
REQ-019 REQ, imem_ack=1, stall=1: capture imem_rdata into 32-bit hold buffer, go HOLD, PC held.
REQ-020 HOLD: if_valid=1, if_inst=hold buffer; stall=0 -> handover, PC <= next PC, go REQ; stall=1 -> remain HOLD.
REQ-021 When if_valid=0, if_inst SHALL be 32'h0000_0000 (nop bubble); if_pc4 SHALL always be PC+4, modulo 2^32 (wraps 32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 Redirect capture: any cycle with stall=0 and pcsource!=00 SHALL latch the selected target into pend_pc and set pend_valid, in any state.
REQ-023 Next PC at handover, priority: pcsource!=00 this cycle -> selected target; else pend_valid -> pend_pc; else PC+4; handover SHALL clear pend_valid.
REQ-024 The fetch in progress when a redirect arrives is the delay slot: it SHALL complete and be presented, never discarded.
REQ-025 pcsource SHALL be ignored in cycles with stall=1.
REQ-026 A second redirect before handover SHALL overwrite pend_pc.
REQ-027 Throughput SHALL be one instruction per cycle with zero-wait memory and no stall.
REQ-028 Target low bits SHALL pass through unmodified; no alignment checking.

Reset
REQ-029 clr=1 SHALL immediately force state RST, PC=RESET_PC, pend_valid=0, hold buffer=0.
REQ-030 During reset: imem_req=0, if_valid=0, if_inst=0, if_pc4=RESET_PC+4.
REQ-031 clr during REQ or HOLD SHALL abandon the fetch; an imem_ack arriving in the RST cycle SHALL be ignored.

Verification
REQ-032 Reset release, ack tied 1, stall 0 -> RST for 1 cycle, then imem_addr 0,4,8,C on successive cycles; if_inst follows rdata with no gap.
REQ-033 Ack at address 8 with stall=1 for 3 cycles -> HOLD; if_inst stays at the address-8 word, if_pc4=C, imem_req=0; handover on the first stall=0 cycle; next addr C.
REQ-034 pcsource=01, bpc=100 while the address-C fetch waits 2 cycles for ack -> word C presented (delay slot); next imem_addr=100; pend_valid cleared.
REQ-035 pcsource=10 with stall=1 -> ignored; PC sequence unchanged.
REQ-036 PC=FFFF_FFFC -> if_pc4=0 and next addr 0.
REQ-037 clr asserted in HOLD -> same cycle: if_valid=0, if_inst=0, PC=RESET_PC; ack during RST ignored.
